// File: rtl/csr_regfile_fifo.sv
// Parametrised CSR register file with per-register access attributes
// and a buffered in-order response queue.
module csr_regfile_fifo #(
    parameter int unsigned RegDataWidth = 32,
    parameter int unsigned RegAddrWidth = 32,
    parameter int unsigned NumRegs      = 16,
    parameter int unsigned RspFifoDepth = 4,
    parameter logic [NumRegs-1:0] RoRegMask    = '0,
    parameter logic [NumRegs-1:0] PulseRegMask = '0,
    parameter logic [NumRegs-1:0] LockRegMask  = '0,
    parameter int unsigned StrbWidth    = RegDataWidth / 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [RegDataWidth-1:0]               req_data_i,
    input  logic [StrbWidth-1:0]                  req_strb_i,
    input  logic [RegAddrWidth-1:0]               req_addr_i,
    input  logic                                  req_write_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    output logic [RegDataWidth-1:0]               rsp_data_o,
    output logic                                  rsp_err_o,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    input  logic                                  busy_i,
    input  logic [NumRegs-1:0][RegDataWidth-1:0]  ro_data_i,
    output logic [NumRegs-1:0][RegDataWidth-1:0]  reg_q_o,
    output logic [NumRegs-1:0]                    wr_en_o,
    output logic [NumRegs-1:0][RegDataWidth-1:0]  pulse_o
);

    localparam int unsigned IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
    localparam int unsigned PtrW = $clog2(RspFifoDepth);

    typedef struct packed {
        logic [RegDataWidth-1:0] data;
        logic                    err;
    } rsp_t;

    logic [NumRegs-1:0][RegDataWidth-1:0] regs_q, regs_d;
    logic [NumRegs-1:0][RegDataWidth-1:0] pulse_q, pulse_d;
    logic [NumRegs-1:0]                   wr_en_q, wr_en_d;

    rsp_t            mem_q [RspFifoDepth];
    logic [PtrW:0]   wptr_q, rptr_q;
    logic            fifo_full, fifo_empty;
    logic            push, pop;

    logic                    in_range;
    logic [IdxW-1:0]         idx;
    logic                    is_ro, is_pulse, is_lock;
    logic                    req_err;
    logic                    wr_ok;
    logic [RegDataWidth-1:0] rd_data;
    logic [RegDataWidth-1:0] strb_mask;

    assign fifo_empty  = (wptr_q == rptr_q);
    assign fifo_full   = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                         (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign req_ready_o = !fifo_full;
    assign push        = req_valid_i & req_ready_o;
    assign rsp_valid_o = !fifo_empty;
    assign pop         = rsp_valid_o & rsp_ready_i;
    assign rsp_data_o  = fifo_empty ? '0 : mem_q[rptr_q[PtrW-1:0]].data;
    assign rsp_err_o   = fifo_empty ? 1'b0 : mem_q[rptr_q[PtrW-1:0]].err;

    assign in_range = (req_addr_i < RegAddrWidth'(NumRegs));
    assign idx      = req_addr_i[IdxW-1:0];

    // RO dominates Pulse, which dominates plain RW
    always_comb begin
        is_ro    = in_range & RoRegMask[idx];
        is_pulse = in_range & !is_ro & PulseRegMask[idx];
        is_lock  = in_range & !is_ro & LockRegMask[idx];
        req_err  = !in_range
                 | (req_write_i & is_ro)
                 | (req_write_i & is_lock & busy_i);
        wr_ok    = push & req_write_i & !req_err;
        rd_data  = '0;
        if (!req_write_i && !req_err) begin
            if (is_ro) begin
                rd_data = ro_data_i[idx];
            end else if (!is_pulse) begin
                rd_data = regs_q[idx];
            end
        end
    end

    always_comb begin
        strb_mask = '0;
        for (int b = 0; b < int'(StrbWidth); b++) begin
            strb_mask[b*8 +: 8] = {8{req_strb_i[b]}};
        end
    end

    always_comb begin
        regs_d  = regs_q;
        wr_en_d = '0;
        pulse_d = '0;
        if (wr_ok) begin
            wr_en_d[idx] = 1'b1;
            if (is_pulse) begin
                pulse_d[idx] = req_data_i & strb_mask;
            end else begin
                regs_d[idx] = (regs_q[idx] & ~strb_mask) |
                              (req_data_i & strb_mask);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q  <= '0;
            wr_en_q <= '0;
            pulse_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            regs_q  <= regs_d;
            wr_en_q <= wr_en_d;
            pulse_q <= pulse_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Entry contents need no reset: the output is gated by fifo_empty
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q[PtrW-1:0]] <= '{data: rd_data, err: req_err};
        end
    end

    assign reg_q_o = regs_q;
    assign wr_en_o = wr_en_q;
    assign pulse_o = pulse_q;

endmodule

// File: tb/tb_csr_regfile_fifo.sv
// Scoreboard bench for csr_regfile_fifo: expected responses queued at
// acceptance and compared as the DUT pops them.
module tb_csr_regfile_fifo;

    localparam int W  = 32;
    localparam int AW = 32;
    localparam int NR = 16;
    localparam int SW = W / 8;

    logic                      clk_i = 1'b0;
    logic                      rst_ni = 1'b0;
    logic [W-1:0]              req_data_i = '0;
    logic [SW-1:0]             req_strb_i = '0;
    logic [AW-1:0]             req_addr_i = '0;
    logic                      req_write_i = 1'b0;
    logic                      req_valid_i = 1'b0;
    logic                      req_ready_o;
    logic [W-1:0]              rsp_data_o;
    logic                      rsp_err_o;
    logic                      rsp_valid_o;
    logic                      rsp_ready_i = 1'b1;
    logic                      busy_i = 1'b0;
    logic [NR-1:0][W-1:0]      ro_data_i = '0;
    logic [NR-1:0][W-1:0]      reg_q_o;
    logic [NR-1:0]             wr_en_o;
    logic [NR-1:0][W-1:0]      pulse_o;

    csr_regfile_fifo #(
        .RegDataWidth (W),
        .RegAddrWidth (AW),
        .NumRegs      (NR),
        .RspFifoDepth (4),
        .RoRegMask    (16'h0002),
        .PulseRegMask (16'h0001),
        .LockRegMask  (16'h0010)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_data_i  (req_data_i),
        .req_strb_i  (req_strb_i),
        .req_addr_i  (req_addr_i),
        .req_write_i (req_write_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .busy_i      (busy_i),
        .ro_data_i   (ro_data_i),
        .reg_q_o     (reg_q_o),
        .wr_en_o     (wr_en_o),
        .pulse_o     (pulse_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    logic [W:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Pop happens on the following posedge; inputs only move at posedge+1
    always @(negedge clk_i) begin
        if (rst_ni && rsp_valid_o && rsp_ready_i) begin
            if (exp_q.size() == 0) begin
                chk("stale_rsp", 64'(rsp_data_o), 64'hDEAD_0000_DEAD);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                chk("rsp_data", 64'(rsp_data_o), 64'(e[W:1]));
                chk("rsp_err", 64'(rsp_err_o), 64'(e[0]));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after acceptance
    task automatic do_req(input bit wr, input int addr,
                          input logic [W-1:0] d, input logic [SW-1:0] s,
                          input logic [W-1:0] ed, input bit ee);
        bit done = 0;
        req_write_i = wr;
        req_addr_i  = AW'(addr);
        req_data_i  = d;
        req_strb_i  = s;
        req_valid_i = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk_i);
            if (req_ready_o) begin
                exp_q.push_back({ed, ee});
                done = 1;
            end
            @(posedge clk_i);
            #1;
        end
        if (!done) chk("req_timeout", 64'd0, 64'd1);
        req_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 200) begin
            @(posedge clk_i);
            #1;
            c++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        ro_data_i[1] = 32'h0000_1234;
        #12;
        chk("rst_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_data", 64'(rsp_data_o), 64'd0);
        chk("rst_err", 64'(rsp_err_o), 64'd0);
        rst_ni = 1'b1;
        tick();
        chk("rst_ready", 64'(req_ready_o), 64'd1);
        chk("rst_regs", 64'(reg_q_o == '0), 64'd1);
        chk("rst_wren", 64'(wr_en_o), 64'd0);
        chk("rst_pulse", 64'(pulse_o == '0), 64'd1);

        do_req(0, 3, '0, '0, 32'h0, 0);
        chk("lat_valid", 64'(rsp_valid_o), 64'd1);

        do_req(1, 2, 32'hDEADBEEF, 4'b0101, 32'h0, 0);
        chk("wr_reg2", 64'(reg_q_o[2]), 64'h00AD00EF);
        chk("wr_en2", 64'(wr_en_o), 64'h0004);
        do_req(0, 2, '0, '0, 32'h00AD00EF, 0);
        chk("wr_en2_off", 64'(wr_en_o), 64'd0);

        do_req(1, 0, 32'h5, 4'hF, 32'h0, 0);
        chk("pulse0", 64'(pulse_o[0]), 64'h5);
        chk("pulse_wren", 64'(wr_en_o), 64'h0001);
        chk("pulse_noreg", 64'(reg_q_o[0]), 64'd0);
        do_req(0, 0, '0, '0, 32'h0, 0);
        chk("pulse0_off", 64'(pulse_o[0]), 64'd0);
        do_req(1, 0, 32'h11223344, 4'b0010, 32'h0, 0);
        chk("pulse_strb", 64'(pulse_o[0]), 64'h3300);

        do_req(1, 1, 32'hFFFF, 4'hF, 32'h0, 1);
        chk("ro_wren", 64'(wr_en_o), 64'd0);
        do_req(0, 1, '0, '0, 32'h1234, 0);

        do_req(0, NR, '0, '0, 32'h0, 1);
        do_req(1, NR, 32'h77, 4'hF, 32'h0, 1);
        chk("oor_wren", 64'(wr_en_o), 64'd0);
        do_req(1, 32'h1_0002, 32'h99, 4'hF, 32'h0, 1);
        chk("oor_alias", 64'(reg_q_o[2]), 64'h00AD00EF);

        busy_i = 1'b1;
        do_req(1, 4, 32'hAAAA, 4'hF, 32'h0, 1);
        chk("lock_reg", 64'(reg_q_o[4]), 64'd0);
        chk("lock_wren", 64'(wr_en_o), 64'd0);
        busy_i = 1'b0;
        do_req(1, 4, 32'hAAAA, 4'hF, 32'h0, 0);
        chk("unlock_reg", 64'(reg_q_o[4]), 64'hAAAA);
        chk("unlock_wren", 64'(wr_en_o), 64'h0010);

        do_req(1, 2, 32'hFFFFFFFF, 4'b0000, 32'h0, 0);
        chk("zstrb_wren", 64'(wr_en_o), 64'h0004);
        chk("zstrb_reg", 64'(reg_q_o[2]), 64'h00AD00EF);
        wait_drain();

        for (int k = 0; k < 6; k++) begin
            do_req(1, 5 + k, 32'hC0DE_0000 + 32'(k), 4'hF, 32'h0, 0);
        end
        wait_drain();

        rsp_ready_i = 1'b0;
        fork
            begin
                repeat (10) @(posedge clk_i);
                #1;
                chk("bp_ready", 64'(req_ready_o), 64'd0);
                chk("bp_count", 64'(exp_q.size()), 64'd4);
                rsp_ready_i = 1'b1;
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    do_req(0, 5 + k, '0, '0, 32'hC0DE_0000 + 32'(k), 0);
                end
            end
        join
        wait_drain();

        rsp_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            do_req(0, 2, '0, '0, 32'h00AD00EF, 0);
        end
        chk("pre_rst_valid", 64'(rsp_valid_o), 64'd1);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 64'(rsp_valid_o), 64'd0);
        chk("arst_regs", 64'(reg_q_o == '0), 64'd1);
        chk("arst_data", 64'(rsp_data_o), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #3;
        rst_ni = 1'b1;
        rsp_ready_i = 1'b1;
        repeat (5) tick();
        chk("post_rst_valid", 64'(rsp_valid_o), 64'd0);
        do_req(0, 2, '0, '0, 32'h0, 0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=hang want=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/csr_regfile_fifo.md
Name: csr_regfile_fifo

Overview:
Generic, parametrised CSR register file. It replaces hand-coded per-core CSR blocks with per-register access attributes (RW, RO, write-one-pulse, busy-locked), byte-strobed writes, address/permission error reporting and a buffered response path. Every accepted request, read or write, produces exactly one response. This lets the host pipeline several requests without stalling. It sits between the host CSR request/response bus and the accelerator core control logic.

Parameters:
- RegDataWidth, 32: register and bus data width; must be a multiple of 8.
- RegAddrWidth, 32: request address width; the address is a word index.
- NumRegs, 16: number of registers, indices 0..NumRegs-1.
- RspFifoDepth, 4: response FIFO entries; power of two, ≥2.
- RoRegMask, '0 (NumRegs bits): bit i=1 makes reg i read-only; reads return ro_data_i[i].
- PulseRegMask, '0 (NumRegs bits): bit i=1 makes reg i write-only pulse; nothing is stored and reads return 0.
- LockRegMask, '0 (NumRegs bits): bit i=1 rejects writes to reg i while busy_i=1.
- StrbWidth, RegDataWidth/8: derived; do not override.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- req_data_i, in, RegDataWidth: write data.
- req_strb_i, in, StrbWidth: byte write enables.
- req_addr_i, in, RegAddrWidth: register index.
- req_write_i, in, 1: 1=write, 0=read.
- req_valid_i, in, 1: request valid.
- req_ready_o, out, 1: request ready.
- rsp_data_o, out, RegDataWidth: read data; 0 for writes.
- rsp_err_o, out, 1: request error flag.
- rsp_valid_o, out, 1: response valid.
- rsp_ready_i, in, 1: response ready.
- busy_i, in, 1: core busy; gates LockRegMask registers.
- ro_data_i, in, NumRegs x RegDataWidth: sources for RO registers.
- reg_q_o, out, NumRegs x RegDataWidth: stored register values.
- wr_en_o, out, NumRegs: one-cycle strobe per register after a successful write.
- pulse_o, out, NumRegs x RegDataWidth: one-cycle pulse of the written bits for pulse registers.

Behaviour:
- Reset values: all stored registers 0, reg_q_o 0, wr_en_o 0, pulse_o 0. FIFO empty, rsp_valid_o 0, rsp_data_o 0, rsp_err_o 0.
- Asserting reset mid-operation flushes all queued responses. Requests in flight are dropped, with no response.
- Accept rule: a request is accepted when req_valid_i & req_ready_o. req_ready_o = !fifo_full. It is a function of registered FIFO state only; there is no same-cycle bypass from a pop.
- Response path: rsp_valid_o = !fifo_empty. rsp_data_o/rsp_err_o show the FIFO head, and 0 when empty. An entry pops on rsp_valid_o & rsp_ready_i.
- Simultaneous push and pop: legal when not full. Occupancy is unchanged and order is strictly FIFO.
- Latency: a request accepted in cycle N gives a response visible at N+1 at the earliest.
- Read data is sampled at acceptance from the pre-update state. A read in N+1 after a write in N returns the new value.
- Error conditions (err=1):
  - addr ≥ NumRegs;
  - a write to a RO register;
  - a write to a LockRegMask register while busy_i=1.
- Error effects: an errored write changes no state and asserts neither wr_en_o nor pulse_o. An errored read returns data 0. An out-of-range read or write has no side effects.
- Successful RW write, accepted at N: byte b of reg i updates at N+1 iff req_strb_i[b]. wr_en_o[i]=1 for cycle N+1 only. An all-zero strobe is still a successful write: wr_en_o pulses, data is unchanged, err=0.
- Successful pulse write: pulse_o[i] = req_data_i masked by the byte-expanded strobe, registered, high for cycle N+1 only, then 0. wr_en_o[i] also pulses. Reads of a pulse register return 0 with err=0.
- Register reads: RW reads return the stored value, RO reads return ro_data_i[i] sampled at acceptance. Reads never error except out of range.
- Mask precedence when bits overlap: RO over Pulse over RW. LockRegMask applies to RW and Pulse registers.
- Back-to-back: one request per cycle, sustained while the FIFO is not full. If rsp_ready_i=0, exactly RspFifoDepth requests are accepted, then req_ready_o=0.

Test Plan:
- Reset, then read reg 3 → rsp_valid_o at N+1, data 0x0, err 0; reg_q_o all 0.
- Write 0xDEADBEEF to reg 2 with strb 4'b0101, then read reg 2 → reg_q_o[2]=0x00AD00EF; wr_en_o[2] high 1 cycle; read data 0x00AD00EF, err 0.
- PulseRegMask[0]=1: write 0x5 to reg 0 → pulse_o[0]=0x5 for one cycle, then 0; read of reg 0 returns 0.
- Error cases:
  - RoRegMask[1]=1: write reg 1 → err 1, no wr_en_o.
  - With ro_data_i[1]=0x1234, read reg 1 → 0x1234.
  - Address NumRegs → err 1, data 0.
  - LockRegMask[4]=1, busy_i=1, write reg 4 → err 1, reg unchanged.
  - With busy_i=0, the same write succeeds.
- Hold rsp_ready_i=0 and issue 6 reads (depth 4) → 4 accepted, req_ready_o=0. Release → responses drain in issue order, then the remaining 2 are accepted.
- Queue 3 responses, then pulse rst_ni low asynchronously → rsp_valid_o=0 immediately; registers 0; no stale responses after reset release.
